// File: rtl/or_and_operand_fifo.sv
// ---------------------------------------------------------------------------
// or_and_operand_fifo
//   Operand staging buffer in front of the OR/AND selector. It queues (A, B)
//   operand pairs and presents the oldest pair first-word-fall-through. The
//   selector reads A[WIDTH-1] as its op bit. That bit passes through untouched.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset (pointers, count, overflow)
//   ena       : block enable; when low nothing is accepted or emitted
//   wr_valid  : producer offers a pair on wr_a / wr_b
//   wr_ready  : pair accepted this cycle (ena and not full)
//   wr_a/wr_b : operand pair in
//   rd_valid  : head pair is presented on rd_a / rd_b (ena and not empty)
//   rd_ready  : selector consumes the head pair this cycle
//   rd_a/rd_b : head operand pair, zero whenever rd_valid is low
//   count     : stored pairs, 0..DEPTH
//   overflow  : sticky, a write was attempted while full and enabled
//   ovf_clr   : synchronous clear of overflow (a new set wins)
// ---------------------------------------------------------------------------
module or_and_operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [WIDTH-1:0]           wr_a,
    input  logic [WIDTH-1:0]           wr_b,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_a,
    output logic [WIDTH-1:0]           rd_b,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Pointers wrap naturally; only the count tells full from empty.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends on registered count only, so a full FIFO never lets a
    // write through on the strength of a same-cycle read.
    assign wr_ready = ena && !w_full;
    assign rd_valid = ena && !w_empty;

    assign w_push = wr_valid && wr_ready;
    assign w_pop  = rd_valid && rd_ready;
    assign w_drop = ena && wr_valid && !wr_ready;

    assign rd_a = rd_valid ? r_mem_a[r_rd_ptr] : '0;
    assign rd_b = rd_valid ? r_mem_b[r_rd_ptr] : '0;

    assign count    = r_count;
    assign overflow = r_overflow;

    // Storage is intentionally not reset; the count guards stale entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= wr_a;
            r_mem_b[r_wr_ptr] <= wr_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A fresh drop takes priority over a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_or_and_operand_fifo.sv
module tb_or_and_operand_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_a;
    logic [WIDTH-1:0] wr_b;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [2:0]       count;
    logic             overflow;
    logic             ovf_clr;

    int checks = 0;
    int errors = 0;

    // Expected pairs {A,B} in the order they must leave the FIFO.
    logic [2*WIDTH-1:0] exp_q[$];

    or_and_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_a     (wr_a),
        .wr_b     (wr_b),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on the falling edge, any presented head must match the
    // oldest expected pair; a handshake retires it.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", {16'h0, rd_a, rd_b}, 32'hDEAD_BEEF);
            end else begin
                chk("rd_pair", {16'h0, rd_a, rd_b}, {16'h0, exp_q[0]});
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [7:0] a, input logic [7:0] b, input logic rr);
        wr_valid = wv;
        wr_a     = a;
        wr_b     = b;
        rd_ready = rr;
    endtask

    // Drive a push that is expected to be accepted at the next edge.
    task automatic push_ok(input logic [7:0] a, input logic [7:0] b, input logic rr);
        drive(1'b1, a, b, rr);
        exp_q.push_back({a, b});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; ovf_clr = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) step();
        chk("rst_count",    32'(count),    0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_ab",    {16'h0, rd_a, rd_b}, 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        rst_n = 1'b1;
        step();

        // Single pair, one-cycle fall-through latency.
        push_ok(8'h85, 8'h0F, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        chk("t1_rd_valid", 32'(rd_valid), 1);
        chk("t1_rd_a",     32'(rd_a),     32'h85);
        chk("t1_rd_b",     32'(rd_b),     32'h0F);
        chk("t1_count",    32'(count),    1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        #1 chk("t1_count_empty", 32'(count), 0);

        // Fill, overflow, clear, set-beats-clear while a pop happens.
        push_ok(8'h01, 8'h11, 1'b0);
        push_ok(8'h82, 8'h22, 1'b0);
        push_ok(8'h03, 8'h33, 1'b0);
        push_ok(8'h84, 8'h44, 1'b0);
        #1;
        chk("t2_count_full", 32'(count),    4);
        chk("t2_wr_ready",   32'(wr_ready), 0);
        drive(1'b1, 8'h05, 8'h55, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        chk("t2_overflow",  32'(overflow), 1);
        chk("t2_count_ovf", 32'(count),    4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        #1 chk("t2_ovf_clr", 32'(overflow), 0);
        drive(1'b1, 8'h05, 8'h55, 1'b1);
        ovf_clr = 1'b1;
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        ovf_clr = 1'b0;
        #1;
        chk("t3_count_pop_only", 32'(count),    3);
        chk("t3_ovf_set_wins",   32'(overflow), 1);
        rd_ready = 1'b1;
        repeat (3) step();
        rd_ready = 1'b0;
        #1 chk("t2_count_drained", 32'(count), 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;

        // Simultaneous push and pop at count=2.
        push_ok(8'h10, 8'hA0, 1'b0);
        push_ok(8'h20, 8'hB0, 1'b0);
        push_ok(8'hFF, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        chk("t4_count_same", 32'(count), 2);
        chk("t4_head_a",     32'(rd_a),  32'h20);
        rd_ready = 1'b1;
        repeat (2) step();
        rd_ready = 1'b0;
        #1 chk("t4_count_drained", 32'(count), 0);

        // Stream ten pairs with the selector always ready; pointers wrap.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] a;
            a = {i[0], 7'(i + 8'h30)};
            push_ok(a, ~a, 1'b1);
            chk("t5_count_le1", 32'(count <= 3'd1), 1);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        step();
        rd_ready = 1'b0;
        #1 chk("t5_count_drained", 32'(count), 0);

        // Disable with three stored, writes attempted and reads offered.
        push_ok(8'hC1, 8'h1C, 1'b0);
        push_ok(8'h42, 8'h24, 1'b0);
        push_ok(8'hE3, 8'h3E, 1'b0);
        ena = 1'b0;
        drive(1'b1, 8'h77, 8'h77, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t6_wr_ready_off", 32'(wr_ready), 0);
            chk("t6_rd_valid_off", 32'(rd_valid), 0);
            chk("t6_rd_ab_off",    {16'h0, rd_a, rd_b}, 0);
            chk("t6_overflow_off", 32'(overflow), 0);
            step();
        end
        ena = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        chk("t6_count_held", 32'(count), 3);
        chk("t6_head_a",     32'(rd_a),  32'hC1);
        chk("t6_head_b",     32'(rd_b),  32'h1C);
        rd_ready = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_count",    32'(count),    0);
        chk("t6_async_rd_valid", 32'(rd_valid), 0);
        rd_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_rst_count", 32'(count), 0);
        chk("scoreboard_empty",  32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
